// File: rtl/pe_alu_xbar.sv
// pe_alu_xbar: CGRA processing-element slice.
// A 4x4 input crossbar picks among in0, in1, the registered ALU result and the
// external FU result. Crossbar outputs 0/1 feed a 2-bit-opcode ALU and outputs
// 2/3 leave the block as external FU operands. A 2x1 switch drives out0.
// The 11 configuration bits sit in a serial scan chain clocked by clk:
//   cfg_q[10:9] = alu_op, cfg_q[8] = osel, cfg_q[7:0] = isel (2 bits per output).
// The datapath keeps running while the chain shifts, so outputs during a load
// follow whatever partial word is in the chain at that moment.
module pe_alu_xbar #(
    parameter int size = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            config_en,
    input  logic            config_in,
    output logic            config_out,
    input  logic [size-1:0] in0,
    input  logic [size-1:0] in1,
    input  logic [size-1:0] ext_in,
    output logic [size-1:0] fu_in0,
    output logic [size-1:0] fu_in1,
    output logic [size-1:0] out0
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    logic [10:0]     cfg_q;
    logic [1:0]      alu_op;
    logic            osel;
    logic [7:0]      isel;

    logic [size-1:0] alu_q;
    logic [size-1:0] alu_d;
    logic [size-1:0] op_a;
    logic [size-1:0] op_b;

    assign alu_op = cfg_q[10:9];
    assign osel   = cfg_q[8];
    assign isel   = cfg_q[7:0];

    // One crossbar lane: 0=in0, 1=in1, 2=alu_q, 3=ext_in
    function automatic logic [size-1:0] xsel(
        input logic [1:0]      sel,
        input logic [size-1:0] s0,
        input logic [size-1:0] s1,
        input logic [size-1:0] s2,
        input logic [size-1:0] s3
    );
        logic [size-1:0] r;
        case (sel)
            2'd0:    r = s0;
            2'd1:    r = s1;
            2'd2:    r = s2;
            default: r = s3;
        endcase
        return r;
    endfunction

    // Config scan chain: new bits enter at the ALU end and exit at bit 0
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_q <= '0;
        end else if (config_en) begin
            cfg_q <= {config_in, cfg_q[10:1]};
        end
    end

    assign config_out = cfg_q[0];

    // Input crossbar: four independent lanes, purely combinational
    always_comb begin
        op_a   = xsel(isel[1:0], in0, in1, alu_q, ext_in);
        op_b   = xsel(isel[3:2], in0, in1, alu_q, ext_in);
        fu_in0 = xsel(isel[5:4], in0, in1, alu_q, ext_in);
        fu_in1 = xsel(isel[7:6], in0, in1, alu_q, ext_in);
    end

    // ALU: all results wrap modulo 2^size; multiply keeps the low half
    always_comb begin
        alu_d = '0;
        case (alu_op)
            OP_ADD:  alu_d = op_a + op_b;
            OP_SUB:  alu_d = op_a - op_b;
            OP_MUL:  alu_d = op_a * op_b;
            OP_AND:  alu_d = op_a & op_b;
            default: alu_d = '0;
        endcase
    end

    // Result register; also breaks the alu_q -> crossbar -> ALU feedback loop
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_q <= '0;
        end else begin
            alu_q <= alu_d;
        end
    end

    // Output switch: ext_in reaches out0 without a register
    always_comb begin
        out0 = osel ? ext_in : alu_q;
    end

endmodule

// File: tb/tb_pe_alu_xbar.sv
// Testbench for pe_alu_xbar: directed scenarios, an opcode vector table and a
// randomized phase checked against a behavioural model of the PE slice.
module tb_pe_alu_xbar;

    logic        clk;
    logic        reset;
    logic        config_en;
    logic        config_in;
    logic        config_out;
    logic [31:0] in0;
    logic [31:0] in1;
    logic [31:0] ext_in;
    logic [31:0] fu_in0;
    logic [31:0] fu_in1;
    logic [31:0] out0;

    int n_pass;
    int n_total;

    // Behavioural model state: the config word as a plain number and the ALU result
    logic [10:0] m_cfg;
    logic [31:0] m_alu;

    pe_alu_xbar #(.size(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .config_en  (config_en),
        .config_in  (config_in),
        .config_out (config_out),
        .in0        (in0),
        .in1        (in1),
        .ext_in     (ext_in),
        .fu_in0     (fu_in0),
        .fu_in1     (fu_in1),
        .out0       (out0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_alu_fn(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [63:0] p;
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2: begin
                p = {32'd0, a} * {32'd0, b};
                return p[31:0];
            end
            default: return a & b;
        endcase
    endfunction

    function automatic logic [31:0] m_lane(input int k);
        logic [31:0] src[4];
        int          idx;
        src[0] = in0;
        src[1] = in1;
        src[2] = m_alu;
        src[3] = ext_in;
        idx = int'((m_cfg >> (2 * k)) & 11'd3);
        return src[idx];
    endfunction

    function automatic logic [31:0] m_out0();
        return m_cfg[8] ? ext_in : m_alu;
    endfunction

    // One clock edge for DUT and model; model evaluates from pre-edge state
    task automatic tick();
        logic [31:0] na;
        logic [10:0] nc;
        na = reset ? 32'd0 : m_alu_fn(m_cfg[10:9], m_lane(0), m_lane(1));
        if (reset)          nc = '0;
        else if (config_en) nc = {config_in, m_cfg[10:1]};
        else                nc = m_cfg;
        @(posedge clk);
        m_alu = na;
        m_cfg = nc;
        #1;
    endtask

    task automatic load_cfg(input logic [10:0] w);
        for (int i = 0; i < 11; i++) begin
            config_en = 1'b1;
            config_in = w[i];
            tick();
        end
        config_en = 1'b0;
        config_in = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".out0"},   out0,            m_out0());
        check({tag, ".fu_in0"}, fu_in0,          m_lane(2));
        check({tag, ".fu_in1"}, fu_in1,          m_lane(3));
        check({tag, ".cfgout"}, {31'd0, config_out}, {31'd0, m_cfg[0]});
    endtask

    initial begin
        logic [10:0] c_load;
        logic [31:0] acc;
        n_pass    = 0;
        n_total   = 0;
        reset     = 1'b1;
        config_en = 1'b0;
        config_in = 1'b0;
        in0       = 32'd5;
        in1       = 32'd7;
        ext_in    = 32'd9;
        m_cfg     = '0;
        m_alu     = '0;
        c_load    = 11'b00_0_11_10_01_00;

        vecs[0] = '{2'd0, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[1] = '{2'd1, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0003};
        vecs[2] = '{2'd2, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[3] = '{2'd3, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0002};
        vecs[4] = '{2'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[5] = '{2'd1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
        vecs[6] = '{2'd2, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000};
        vecs[7] = '{2'd2, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F};
        vecs[8] = '{2'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0};

        // Reset with in0=5, in1=7, ext_in=9
        tick();
        reset = 1'b0;
        check("rst.out0",   out0,   32'd0);
        check("rst.cfgout", {31'd0, config_out}, 32'd0);
        check("rst.fu_in0", fu_in0, 32'd5);
        check("rst.fu_in1", fu_in1, 32'd5);
        tick();
        check("rst.next_out0", out0, 32'd10);

        // Config load: A=in0, B=in1, fu_in0=alu_q, fu_in1=ext_in, ADD
        load_cfg(c_load);
        in0 = 32'd3;
        in1 = 32'd4;
        tick();
        check("load.out0",   out0,   32'd7);
        check("load.fu_in0", fu_in0, 32'd7);
        check("load.fu_in1", fu_in1, 32'd9);
        for (int i = 0; i < 11; i++) begin
            check($sformatf("load.shout%0d", i), {31'd0, config_out}, {31'd0, c_load[i]});
            config_en = 1'b1;
            config_in = 1'b0;
            tick();
        end
        config_en = 1'b0;
        check("load.empty", {31'd0, config_out}, 32'd0);

        // Opcode table: ISEL A=in0, B=in1
        for (int v = 0; v < 9; v++) begin
            load_cfg({vecs[v].op, 1'b0, 8'h04});
            in0 = vecs[v].a;
            in1 = vecs[v].b;
            tick();
            check($sformatf("op%0d", v), out0, vecs[v].exp);
        end

        // Accumulate: A=alu_q, B=in0; zero inputs keep alu_q at 0 during load
        in0 = 32'd0; in1 = 32'd0; ext_in = 32'd0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        load_cfg({2'b00, 1'b0, 8'h02});
        check("acc.start", out0, 32'd0);
        in0 = 32'd1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("acc%0d", i), out0, i);
        end
        in0 = 32'hFFFF_FFFA;
        tick();
        check("acc.max", out0, 32'hFFFF_FFFF);
        in0 = 32'd1;
        tick();
        check("acc.wrap", out0, 32'd0);
        tick();
        check("acc.after", out0, 32'd1);

        // Output switch: ext_in reaches out0 without a clock
        load_cfg({2'b00, 1'b1, 8'h00});
        ext_in = 32'hDEAD_BEEF;
        #1;
        check("osel.ext", out0, 32'hDEAD_BEEF);
        ext_in = 32'h1234_5678;
        #1;
        check("osel.comb", out0, 32'h1234_5678);

        // Reset in the middle of a load discards the partial word
        in0 = 32'd5; in1 = 32'd7; ext_in = 32'd9;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            config_en = 1'b1;
            config_in = c_load[i];
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        config_en = 1'b0;
        check("midrst.cfgout", {31'd0, config_out}, 32'd0);
        check("midrst.out0",   out0,   32'd0);
        check("midrst.fu_in0", fu_in0, 32'd5);
        check("midrst.fu_in1", fu_in1, 32'd5);
        load_cfg(c_load);
        in0 = 32'd3;
        in1 = 32'd4;
        tick();
        check("midrst.out0_7", out0,   32'd7);
        check("midrst.fu_in1", fu_in1, 32'd9);

        // Randomized phase against the behavioural model
        acc = 32'd0;
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 49) == 0);
            config_en = $urandom_range(0, 1) == 1;
            config_in = $urandom_range(0, 1) == 1;
            in0       = $urandom();
            in1       = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
            ext_in    = $urandom();
            #1;
            check_model($sformatf("rnd%0d.pre", i));
            tick();
            check_model($sformatf("rnd%0d", i));
            acc = acc + 32'd1;
        end
        reset     = 1'b0;
        config_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
